// File: rtl/rr_arbiter.sv
// N-requester arbiter with registered one-hot grant, round-robin or fixed
// priority selection, and an optional maximum-hold counter for fair rotation.

module rr_arbiter_lane #(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int LANE    = 0,
  parameter int RR_MODE = 1
) (
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     cand,
  output logic             win
);
  // Search rank of requester j: distance from ptr (with wrap) or plain index.
  function automatic int rank(input int j, input int p);
    if (RR_MODE == 0) return j;
    return (j >= p) ? (j - p) : (j + N - p);
  endfunction

  always_comb begin
    win = cand[LANE];
    for (int j = 0; j < N; j++) begin
      if (j != LANE && cand[j] && rank(j, int'(ptr)) < rank(LANE, int'(ptr)))
        win = 1'b0;
    end
  end
endmodule

module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(N),
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);
  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [CNT_W-1:0] HOLD     = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state, state_n;
  logic [N-1:0]     grant_n;
  logic [IDX_W-1:0] idx_n, ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [N-1:0]     cand, sel_oh;
  logic             sel_any, take;
  logic [IDX_W-1:0] sel_idx;

  // Masking out the current owner covers every case: in IDLE grant is zero,
  // and on release req[owner] is already low.
  assign cand    = req & ~grant;
  assign sel_any = |cand;

  for (genvar i = 0; i < N; i++) begin : g_lane
    rr_arbiter_lane #(
      .N(N), .IDX_W(IDX_W), .LANE(i), .RR_MODE(RR_MODE)
    ) u_lane (
      .ptr  (ptr),
      .cand (cand),
      .win  (sel_oh[i])
    );
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++)
      if (sel_oh[i]) sel_idx = sel_idx | IDX_W'(i);
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    idx_n   = grant_idx;
    cnt_n   = cnt;
    ptr_n   = ptr;
    take    = 1'b0;
    case (state)
      IDLE: if (|req) take = 1'b1;
      OWNED: begin
        if (!req[grant_idx]) begin
          if (sel_any) take = 1'b1;
          else begin
            state_n = IDLE;
            grant_n = '0;
            idx_n   = '0;
            cnt_n   = '0;
          end
        end else if (MAX_HOLD == 0 || cnt < HOLD) begin
          cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end else if (sel_any) begin
          take = 1'b1;
        end else begin
          cnt_n = CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (take) begin
      state_n = OWNED;
      grant_n = sel_oh;
      idx_n   = sel_idx;
      cnt_n   = CNT_W'(1);
      ptr_n   = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      cnt       <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      grant_idx <= idx_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
    end
  end

  assign grant_valid = (state == OWNED);
endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: three instances (RR, RR+MAX_HOLD=2, fixed
// priority) driven by directed and random requests against a reference model.

module tb_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rq [3];
  logic [3:0] g  [3];
  logic       v  [3];
  logic [1:0] ix [3];

  rr_arbiter #(.N(4), .RR_MODE(1), .MAX_HOLD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(rq[0]), .grant(g[0]), .grant_valid(v[0]), .grant_idx(ix[0]));
  rr_arbiter #(.N(4), .RR_MODE(1), .MAX_HOLD(2)) u1 (
    .clk(clk), .rst_n(rst_n), .req(rq[1]), .grant(g[1]), .grant_valid(v[1]), .grant_idx(ix[1]));
  rr_arbiter #(.N(4), .RR_MODE(0), .MAX_HOLD(0)) u2 (
    .clk(clk), .rst_n(rst_n), .req(rq[2]), .grant(g[2]), .grant_valid(v[2]), .grant_idx(ix[2]));

  typedef struct {
    int         inst;
    logic [3:0] g;
    logic       v;
    logic [1:0] ix;
  } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: owner (-1 = none), rotating pointer, hold count.
  int rrm [3] = '{1, 1, 0};
  int mhm [3] = '{0, 2, 0};
  int m_own [3];
  int m_ptr [3];
  int m_cnt [3];

  task automatic check(input string nm, input int i, input logic [3:0] eg,
                       input logic ev, input logic [1:0] ei);
    n_chk++;
    if (g[i] !== eg || v[i] !== ev || ix[i] !== ei) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got grant=%b valid=%b idx=%0d, want grant=%b valid=%b idx=%0d",
               nm, i, $time, g[i], v[i], ix[i], eg, ev, ei);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_own[i] = -1;
      m_ptr[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  function automatic int pick(input int i, input logic [3:0] r, input int excl);
    for (int s = 0; s < 4; s++) begin
      int j;
      j = (rrm[i] != 0) ? (m_ptr[i] + s) % 4 : s;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic m_grant(input int i, input int o);
    m_own[i] = o;
    m_cnt[i] = 1;
    m_ptr[i] = (o + 1) % 4;
  endtask

  task automatic m_step(input int i, input logic [3:0] r);
    int k, o;
    k = m_own[i];
    if (k < 0) begin
      if (r != 4'b0) m_grant(i, pick(i, r, -1));
    end else if (!r[k]) begin
      o = pick(i, r, k);
      if (o >= 0) m_grant(i, o);
      else m_own[i] = -1;
    end else if (mhm[i] == 0 || m_cnt[i] < mhm[i]) begin
      if (m_cnt[i] < 255) m_cnt[i]++;
    end else begin
      o = pick(i, r, k);
      if (o >= 0) m_grant(i, o);
      else m_cnt[i] = 1;
    end
  endtask

  task automatic cycle(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    exp_t e;
    @(negedge clk);
    #1;
    rq[0] = a; rq[1] = b; rq[2] = c;
    for (int i = 0; i < 3; i++) begin
      m_step(i, rq[i]);
      e.inst = i;
      e.v    = (m_own[i] >= 0);
      e.g    = e.v ? 4'(1 << m_own[i]) : 4'b0;
      e.ix   = e.v ? 2'(m_own[i]) : 2'd0;
      q.push_back(e);
    end
  endtask

  // Monitor: outputs are compared on the falling edge after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        check("sb", e.inst, e.g, e.v, e.ix);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [3:0] nr [3];
    m_reset();
    for (int i = 0; i < 3; i++) rq[i] = 4'hF;
    #1;
    for (int i = 0; i < 3; i++) check("reset_noedge", i, 4'b0, 1'b0, 2'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) check("reset_hold", i, 4'b0, 1'b0, 2'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rq[i] = 4'h0;
    rst_n = 1'b1;

    // Lock, rotation, fixed-priority release, then wrap handoff and idle.
    repeat (11) cycle(4'hF, 4'hF, 4'h4);
    cycle(4'hE, 4'hF, 4'hA);
    cycle(4'h8, 4'hF, 4'h4);
    cycle(4'h1, 4'hF, 4'hA);
    cycle(4'h0, 4'hF, 4'h4);
    cycle(4'h0, 4'h0, 4'hA);
    cycle(4'h0, 4'h0, 4'h4);
    cycle(4'h0, 4'h0, 4'hA);

    repeat (400) begin
      for (int i = 0; i < 3; i++)
        nr[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : rq[i];
      cycle(nr[0], nr[1], nr[2]);
    end

    // Asynchronous reset while inst1 owns requester 2 with cnt = 1.
    cycle(4'h0, 4'h0, 4'h0);
    cycle(4'h0, 4'h4, 4'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check("async_rst", i, 4'b0, 1'b0, 2'd0);
    m_reset();
    for (int i = 0; i < 3; i++) rq[i] = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'hF, 4'hF, 4'hF);
    cycle(4'hF, 4'hF, 4'hF);
    @(negedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
